load_store_unit: RTL
====================

# load_store_unit

Sequential load/store unit between the processor datapath and the word-addressed, single-port data memory. It accepts one byte, halfword or word request at a time over a valid/ready handshake and checks alignment and range. It performs sub-word stores as read-modify-write, because the data memory has no byte enables. Loaded data is returned extracted and sign- or zero-extended.

## Interface
- DEPTH_WORDS, 64: number of 32-bit words in the data memory; legal word index range is 0..DEPTH_WORDS-1.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; the low byte or halfword is used for SB/SH.
- resp_valid  output  1  one-cycle completion pulse, for both loads and stores.
- resp_rdata  output  32  extended load result; 0 for stores and errors.
- resp_err  output  1  request rejected; valid only with resp_valid.
- mem_addr  output  32  word index, equal to the latched address[31:2] zero-extended.
- mem_read  output  1  memory read enable; memory read is combinational.
- mem_write  output  1  memory write enable; memory writes at the clk edge.
- mem_wdata  output  32  word to write.
- mem_rdata  input  32  word read from memory.

## Operation
- States: IDLE, LOAD, RMW_READ, WRITE, RESP.
- In IDLE, req_ready=1. Handshake: a request is accepted at an edge where req_valid && req_ready. On accept, latch write, funct3, addr and wdata. req_ready=0 in every other state, and req_ready=0 while reset is high.
- Error check is done at accept, on the raw request:
  - misaligned: halfword with addr[0]=1; word with addr[1:0]≠0.
  - illegal funct3: loads 011/110/111; stores ≥011.
  - out of range: addr[31:2] ≥ DEPTH_WORDS.
  - Any error: go to RESP with err=1 and rdata=0. mem_read and mem_write are never asserted for that request.
- Legal transitions:
  - load: IDLE→LOAD→RESP.
  - SW: IDLE→WRITE→RESP.
  - SB/SH: IDLE→RMW_READ→WRITE→RESP.
- LOAD: mem_read=1. At the edge, register the extracted value. The byte lane is addr[1:0] (little-endian); the halfword lane is addr[1]. LB/LH sign-extend; LBU/LHU zero-extend.
- RMW_READ: mem_read=1. At the edge, register the merged word: mem_rdata with the selected byte or halfword lane replaced by req_wdata[7:0] or [15:0].
- WRITE: mem_write=1. mem_wdata is the merged word (SB/SH) or the latched wdata (SW).
- RESP: resp_valid=1 for exactly one cycle, then IDLE. A new request is not accepted in the same cycle; the next accept can occur in the following IDLE cycle.
- mem_read, mem_write and resp_valid are decoded from state only.
- mem_addr and mem_wdata are 0 whenever the strobe using them is low.
- Reset values: state IDLE; resp_valid=0, resp_err=0, resp_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, all latched request fields 0.
- Reset mid-operation: the request is abandoned immediately and no response is issued. Because mem_write is state-decoded, reset asserted during WRITE drops it before the edge. The memory word is then either fully old or, if the write edge completed first, fully new — never partially merged.

## Timing
- Load latency: accept edge E0, LOAD cycle, result registered at E1, resp_valid high during the cycle after E1, request-to-response 2 edges.
- SW: write committed at E1, resp_valid after E1.
- SB/SH: read at E1, write committed at E2, resp_valid after E2.
- Error: resp_valid in the cycle after E0.
- Throughput: one request per 3 cycles (load, SW), 4 cycles (SB/SH), 2 cycles (error).
- mem_rdata is sampled only at the end of LOAD and RMW_READ cycles, so it only needs to settle within a single cycle.
- resp_rdata and resp_err hold their values until the next response. Their value is only meaningful while resp_valid=1.

## Test plan
- SW addr 0x10, data 0xDEADBEEF, then LW 0x10 → one mem_write to word 4; resp_rdata=0xDEADBEEF, err=0, response 2 edges after accept.
- With word 4 = 0xDEADBEEF, SB addr 0x13 data 0x12 → RMW read then write; word 4 = 0x12ADBEEF; LBU 0x13 → 0x00000012.
- With word 4 = 0x12ADBEEF: LB 0x12 → 0xFFFFFFAD; LH 0x12 → 0x000012AD; LHU 0x10 → 0x0000BEEF.
- LW addr 0x06, SH addr 0x01, LB addr 0x100 (word 64), funct3 011 load → each gives err=1 and rdata=0; mem_read and mem_write stay 0 throughout.
- Reset asserted during RMW_READ of SH 0x20 → immediately state IDLE, no mem_write, no resp_valid; word 8 unchanged; after release, req_ready=1 and a new LW completes normally.
- Back-to-back: req_valid held high with 3 queued requests → each accepted only in IDLE; exactly one resp_valid pulse per request, in order; req_ready never high outside IDLE.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit between the datapath and a word-addressed data memory without byte enables.
// Sub-word stores are done as read-modify-write; loads are lane-extracted and sign/zero-extended.
module load_store_unit #(
   parameter int DEPTH_WORDS = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_addr,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam logic [31:0] DEPTH_LIMIT = 32'(DEPTH_WORDS);

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      RMW_READ,
      WRITE,
      RESP
   } state_t;

   state_t      state;
   logic        lat_write;
   logic [2:0]  lat_funct3;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;
   logic [31:0] merged_word;

   logic        req_illegal;
   logic        req_misaligned;
   logic        req_out_of_range;
   logic        req_error;

   logic [7:0]  load_byte;
   logic [15:0] load_half;
   logic [31:0] load_value;
   logic [31:0] merge_next;

   // Rejection is decided on the raw request so erroneous requests never touch memory.
   always_comb begin
      req_illegal      = 1'b0;
      req_misaligned   = 1'b0;
      req_out_of_range = 1'b0;
      if (req_write) begin
         req_illegal = (req_funct3 >= 3'b011);
      end else begin
         req_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                       (req_funct3 == 3'b111);
      end
      case (req_funct3[1:0])
         2'b01:   req_misaligned = req_addr[0];
         2'b10:   req_misaligned = (req_addr[1:0] != 2'b00);
         default: req_misaligned = 1'b0;
      endcase
      req_out_of_range = ({2'b00, req_addr[31:2]} >= DEPTH_LIMIT);
      req_error = req_illegal || req_misaligned || req_out_of_range;
   end

   // Little-endian lane selection from the word currently on mem_rdata.
   always_comb begin
      load_byte = 8'h00;
      case (lat_addr[1:0])
         2'b00:   load_byte = mem_rdata[7:0];
         2'b01:   load_byte = mem_rdata[15:8];
         2'b10:   load_byte = mem_rdata[23:16];
         default: load_byte = mem_rdata[31:24];
      endcase
      load_half = lat_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      load_value = mem_rdata;
      case (lat_funct3)
         F3_LB:   load_value = {{24{load_byte[7]}}, load_byte};
         F3_LH:   load_value = {{16{load_half[15]}}, load_half};
         F3_LW:   load_value = mem_rdata;
         F3_LBU:  load_value = {24'h000000, load_byte};
         F3_LHU:  load_value = {16'h0000, load_half};
         default: load_value = mem_rdata;
      endcase
   end

   always_comb begin
      merge_next = mem_rdata;
      if (lat_funct3[1:0] == 2'b00) begin
         case (lat_addr[1:0])
            2'b00:   merge_next[7:0]   = lat_wdata[7:0];
            2'b01:   merge_next[15:8]  = lat_wdata[7:0];
            2'b10:   merge_next[23:16] = lat_wdata[7:0];
            default: merge_next[31:24] = lat_wdata[7:0];
         endcase
      end else if (lat_addr[1]) begin
         merge_next[31:16] = lat_wdata[15:0];
      end else begin
         merge_next[15:0] = lat_wdata[15:0];
      end
   end

   // Single request FSM; response fields only change when a new response is produced.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         lat_write   <= 1'b0;
         lat_funct3  <= 3'b000;
         lat_addr    <= 32'h0;
         lat_wdata   <= 32'h0;
         merged_word <= 32'h0;
         resp_rdata  <= 32'h0;
         resp_err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  lat_write  <= req_write;
                  lat_funct3 <= req_funct3;
                  lat_addr   <= req_addr;
                  lat_wdata  <= req_wdata;
                  if (req_error) begin
                     resp_err   <= 1'b1;
                     resp_rdata <= 32'h0;
                     state      <= RESP;
                  end else if (!req_write) begin
                     state <= LOAD;
                  end else if (req_funct3 == F3_LW) begin
                     state <= WRITE;
                  end else begin
                     state <= RMW_READ;
                  end
               end
            end
            LOAD: begin
               resp_rdata <= load_value;
               resp_err   <= 1'b0;
               state      <= RESP;
            end
            RMW_READ: begin
               merged_word <= merge_next;
               state       <= WRITE;
            end
            WRITE: begin
               resp_rdata <= 32'h0;
               resp_err   <= 1'b0;
               state      <= RESP;
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Strobes come straight from state so an async reset drops a pending write before its edge.
   always_comb begin
      req_ready  = (state == IDLE) && !reset;
      mem_read   = (state == LOAD) || (state == RMW_READ);
      mem_write  = (state == WRITE);
      resp_valid = (state == RESP);
      mem_addr   = 32'h0;
      mem_wdata  = 32'h0;
      if (mem_read || mem_write) begin
         mem_addr = {2'b00, lat_addr[31:2]};
      end
      if (mem_write) begin
         mem_wdata = (lat_write && lat_funct3 == F3_LW) ? lat_wdata : merged_word;
      end
   end

endmodule
